wd_burst_tracker: RTL and testbench
===================================

Name: wd_burst_tracker

Overview:
- Parametrised multi-channel write-data (W) channel handshake tracker for the AXI interconnect.
- Per channel: loads the expected burst length when the address phase is accepted, counts accepted W beats and checks WLAST position.
- Raises a sticky done flag that the arbiter/response logic acknowledges.
- Sits between the W-channel mux and the B-channel response logic; replaces single-channel done-pulse handshakes.

Parameters:
- NUM_CH, 2, number of independent write channels tracked.
- LEN_W, 8, width of the AXI burst length field (AWLEN, beats minus 1).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous active-high reset.
- Burst_Start  in  NUM_CH  per-channel pulse: AW accepted; load length.
- Burst_Len  in  NUM_CH*LEN_W  per-channel AWLEN; channel i occupies bits [i*LEN_W +: LEN_W].
- Valid_Signal  in  NUM_CH  per-channel WVALID.
- Ready_Signal  in  NUM_CH  per-channel WREADY.
- Last_Data  in  NUM_CH  per-channel WLAST.
- HandShake_En  in  NUM_CH  per-channel acknowledge; clears done.
- HandShake_Done  out  NUM_CH  per-channel burst complete, held until acknowledged.
- Busy  out  NUM_CH  per-channel burst in progress.
- Len_Err  out  NUM_CH  per-channel sticky WLAST position error.
- Beat_Count  out  NUM_CH*LEN_W  per-channel beats accepted in the current burst (0-based).
- Burst_Cnt  out  NUM_CH*16  per-channel completed-burst counter (see Optional Feature).

Behaviour:
- Reset: while ARESET=1 at a clock edge, all outputs go to 0, every FSM goes to IDLE and all counters clear. Reset mid-burst abandons the burst silently; no done pulse is produced.
- Channels are fully independent; there is no cross-channel interaction.
- Beat accepted on channel i: Valid_Signal[i] & Ready_Signal[i] while that channel is in ACTIVE.
- FSM per channel has states IDLE, ACTIVE and DONE.
- IDLE:
  - Burst_Start=1: latch Burst_Len into exp_len, clear Beat_Count and Len_Err, go to ACTIVE.
  - Handshakes seen in IDLE are ignored.
- ACTIVE (Busy=1):
  - Accepted beat with Beat_Count != exp_len and Last_Data=0: Beat_Count increments.
  - Accepted beat with Beat_Count == exp_len: final beat; go to DONE. If Last_Data=0 on this beat (late/missing last), set Len_Err.
  - Accepted beat with Last_Data=1 and Beat_Count < exp_len (early last): set Len_Err and go to DONE.
  - Burst_Start while in ACTIVE is ignored.
  - Beat_Count holds after the terminating beat.
- DONE:
  - HandShake_Done=1, Busy=0.
  - HandShake_En=1: go to IDLE and clear HandShake_Done next cycle.
  - HandShake_En and Burst_Start in the same cycle: go directly to ACTIVE, load the new length, clear Len_Err and Beat_Count.
  - Burst_Start without HandShake_En: ignored.
  - HandShake_En in IDLE or ACTIVE: no effect.
- Latency: HandShake_Done rises one cycle after the edge at which the terminating beat is accepted. Busy rises one cycle after Burst_Start.
- exp_len = 0 (single beat): the first accepted beat terminates the burst.
- Maximum burst is 2^LEN_W beats. Beat_Count never wraps because it stops at exp_len.
- Len_Err is sticky until the next accepted Burst_Start or reset. It is valid together with HandShake_Done.

Optional Feature:
- Macro: WD_HS_PERF_CNT_EN.
- Defined:
  - Burst_Cnt[i] increments by 1 on each ACTIVE->DONE transition of channel i.
  - The counter saturates at 16'hFFFF and clears only on ARESET.
- Not defined: Burst_Cnt is driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset: ARESET=1 for 2 cycles mid-burst on ch0 (after 3 beats of Burst_Len=7) -> all outputs 0. A following Burst_Start is required to start a new burst.
- Nominal: ch0 Burst_Len=3, 4 beats with Last on beat 4 -> Done=1 one cycle after beat 4, Len_Err=0, Beat_Count=3, Done holds until HandShake_En, then 0 next cycle.
- Early last: ch1 Burst_Len=5, Last on beat 3 -> DONE entered, Len_Err=1, Beat_Count=2, Done=1. Beats 4-6 offered afterwards are ignored.
- Late last: ch0 Burst_Len=1, beat 2 without Last -> Done=1, Len_Err=1.
- Back-to-back: ch0 in DONE, HandShake_En and Burst_Start(Len=0) in the same cycle -> Busy=1 next cycle, Len_Err cleared. One beat with Last -> Done=1.
- Independence/perf: ch0 and ch1 run concurrent bursts (Len=2 and Len=0), with Valid stalls and Ready stalls -> each Done is correct and independent. With WD_HS_PERF_CNT_EN defined, Burst_Cnt ch0=1 and ch1=1; without it, both are 0.

Source files
------------

// File: rtl/wd_burst_tracker.sv
//------------------------------------------------------------------------------
// Module   : wd_burst_tracker
// Purpose  : Multi-channel AXI write-data (W) handshake tracker. For each
//            channel, the expected burst length is captured when the address
//            phase is accepted. Accepted W beats are then counted and the WLAST
//            position is checked. A sticky done flag is held until the
//            response/arbiter logic acknowledges it.
// Options  : `define WD_HS_PERF_CNT_EN adds a saturating 16-bit completed-burst
//            counter per channel. Without it, Burst_Cnt is tied to 0.
// Ports    : ACLK           clock, rising edge
//            ARESET         synchronous active-high reset
//            Burst_Start    [NUM_CH]        AW accepted, load length
//            Burst_Len      [NUM_CH*LEN_W]  AWLEN per channel
//            Valid_Signal   [NUM_CH]        WVALID
//            Ready_Signal   [NUM_CH]        WREADY
//            Last_Data      [NUM_CH]        WLAST
//            HandShake_En   [NUM_CH]        acknowledge, clears done
//            HandShake_Done [NUM_CH]        burst complete (held until ack)
//            Busy           [NUM_CH]        burst in progress
//            Len_Err        [NUM_CH]        sticky WLAST position error
//            Beat_Count     [NUM_CH*LEN_W]  beats accepted in burst (0-based)
//            Burst_Cnt      [NUM_CH*16]     completed-burst counter
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wd_burst_tracker #(
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [NUM_CH-1:0]       Burst_Start,
  input  logic [NUM_CH*LEN_W-1:0] Burst_Len,
  input  logic [NUM_CH-1:0]       Valid_Signal,
  input  logic [NUM_CH-1:0]       Ready_Signal,
  input  logic [NUM_CH-1:0]       Last_Data,
  input  logic [NUM_CH-1:0]       HandShake_En,
  output logic [NUM_CH-1:0]       HandShake_Done,
  output logic [NUM_CH-1:0]       Busy,
  output logic [NUM_CH-1:0]       Len_Err,
  output logic [NUM_CH*LEN_W-1:0] Beat_Count,
  output logic [NUM_CH*16-1:0]    Burst_Cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]       state;
      logic [LEN_W-1:0] exp_len;
      logic [LEN_W-1:0] beat_cnt;
      logic             len_err;
      logic             beat;
      logic             final_beat;
      logic             terminate;

      assign beat       = Valid_Signal[i] & Ready_Signal[i] & (state == ST_ACTIVE);
      assign final_beat = (beat_cnt == exp_len);
      // A burst ends on the expected final beat or on any WLAST, whichever
      // comes first.
      assign terminate  = beat & (final_beat | Last_Data[i]);

      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          state    <= ST_IDLE;
          exp_len  <= '0;
          beat_cnt <= '0;
          len_err  <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (Burst_Start[i]) begin
                exp_len  <= Burst_Len[i*LEN_W +: LEN_W];
                beat_cnt <= '0;
                len_err  <= 1'b0;
                state    <= ST_ACTIVE;
              end
            end
            ST_ACTIVE: begin
              if (terminate) begin
                // WLAST must coincide exactly with the final expected beat.
                // A mismatch in either direction flags an error.
                // beat_cnt holds so it reports the final index.
                state <= ST_DONE;
                if (final_beat != Last_Data[i]) len_err <= 1'b1;
              end else if (beat) begin
                beat_cnt <= beat_cnt + LEN_ONE;
              end
            end
            ST_DONE: begin
              if (HandShake_En[i]) begin
                if (Burst_Start[i]) begin
                  // Ack and new address in the same cycle: restart directly.
                  exp_len  <= Burst_Len[i*LEN_W +: LEN_W];
                  beat_cnt <= '0;
                  len_err  <= 1'b0;
                  state    <= ST_ACTIVE;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end

      assign HandShake_Done[i]              = (state == ST_DONE);
      assign Busy[i]                        = (state == ST_ACTIVE);
      assign Len_Err[i]                     = len_err;
      assign Beat_Count[i*LEN_W +: LEN_W]   = beat_cnt;

`ifdef WD_HS_PERF_CNT_EN
      logic [15:0] burst_cnt;

      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          burst_cnt <= '0;
        end else if (terminate && (burst_cnt != 16'hFFFF)) begin
          burst_cnt <= burst_cnt + 16'd1;
        end
      end

      assign Burst_Cnt[i*16 +: 16] = burst_cnt;
`else
      assign Burst_Cnt[i*16 +: 16] = 16'd0;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wd_burst_tracker.sv
//------------------------------------------------------------------------------
// Module   : tb_wd_burst_tracker
// Purpose  : Self-checking bench for wd_burst_tracker. It runs directed
//            scenarios followed by randomized traffic. All stimulus is compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wd_burst_tracker;

  localparam int NUM_CH = 2;
  localparam int LEN_W  = 8;

  logic                    ACLK = 1'b0;
  logic                    ARESET;
  logic [NUM_CH-1:0]       Burst_Start;
  logic [NUM_CH*LEN_W-1:0] Burst_Len;
  logic [NUM_CH-1:0]       Valid_Signal;
  logic [NUM_CH-1:0]       Ready_Signal;
  logic [NUM_CH-1:0]       Last_Data;
  logic [NUM_CH-1:0]       HandShake_En;
  logic [NUM_CH-1:0]       HandShake_Done;
  logic [NUM_CH-1:0]       Busy;
  logic [NUM_CH-1:0]       Len_Err;
  logic [NUM_CH*LEN_W-1:0] Beat_Count;
  logic [NUM_CH*16-1:0]    Burst_Cnt;

  wd_burst_tracker #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .Burst_Start   (Burst_Start),
    .Burst_Len     (Burst_Len),
    .Valid_Signal  (Valid_Signal),
    .Ready_Signal  (Ready_Signal),
    .Last_Data     (Last_Data),
    .HandShake_En  (HandShake_En),
    .HandShake_Done(HandShake_Done),
    .Busy          (Busy),
    .Len_Err       (Len_Err),
    .Beat_Count    (Beat_Count),
    .Burst_Cnt     (Burst_Cnt)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference: per channel, track whether a burst is in
  // flight, whether it awaits acknowledge, the total beats accepted and the
  // burst length in beats.
  bit m_inflight [NUM_CH];
  bit m_waiting  [NUM_CH];
  bit m_err      [NUM_CH];
  bit m_ended    [NUM_CH];
  int m_beats    [NUM_CH];
  int m_total    [NUM_CH];
  int m_bursts   [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_inflight[c] = 0; m_waiting[c] = 0; m_err[c] = 0; m_ended[c] = 0;
      m_beats[c] = 0; m_total[c] = 0; m_bursts[c] = 0;
    end
  endtask

  task automatic model_start(input int c);
    m_inflight[c] = 1;
    m_err[c]      = 0;
    m_ended[c]    = 0;
    m_beats[c]    = 0;
    m_total[c]    = int'(Burst_Len[c*LEN_W +: LEN_W]) + 1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    if (ARESET) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_inflight[c]) begin
        if (Valid_Signal[c] && Ready_Signal[c]) begin
          m_beats[c]++;
          if (Last_Data[c] || m_beats[c] == m_total[c]) begin
            m_inflight[c] = 0;
            m_waiting[c]  = 1;
            m_ended[c]    = 1;
            // Error unless WLAST arrives exactly on the last expected beat.
            m_err[c]      = Last_Data[c] ^ (m_beats[c] == m_total[c]);
            if (m_bursts[c] < 65535) m_bursts[c]++;
          end
        end
      end else if (m_waiting[c]) begin
        if (HandShake_En[c]) begin
          m_waiting[c] = 0;
          if (Burst_Start[c]) model_start(c);
        end
      end else if (Burst_Start[c]) begin
        model_start(c);
      end
    end
  endtask

  task automatic compare_all();
    int exp_bc;
    int exp_pc;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_bc = m_ended[c] ? m_beats[c] - 1 : m_beats[c];
`ifdef WD_HS_PERF_CNT_EN
      exp_pc = m_bursts[c];
`else
      exp_pc = 0;
`endif
      check($sformatf("done%0d", c),  32'(HandShake_Done[c]), 32'(m_waiting[c]));
      check($sformatf("busy%0d", c),  32'(Busy[c]),           32'(m_inflight[c]));
      check($sformatf("err%0d", c),   32'(Len_Err[c]),        32'(m_err[c]));
      check($sformatf("bcnt%0d", c),  32'(Beat_Count[c*LEN_W +: LEN_W]), 32'(exp_bc));
      check($sformatf("perf%0d", c),  32'(Burst_Cnt[c*16 +: 16]),        32'(exp_pc));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge ACLK);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    ARESET = 1'b0; Burst_Start = '0; Valid_Signal = '0; Ready_Signal = '0;
    Last_Data = '0; HandShake_En = '0;
  endtask

  task automatic beat(input int c, input bit last);
    idle_inputs();
    Valid_Signal[c] = 1'b1; Ready_Signal[c] = 1'b1; Last_Data[c] = last;
    step();
  endtask

  task automatic start(input int c, input int len);
    idle_inputs();
    Burst_Start[c] = 1'b1;
    Burst_Len[c*LEN_W +: LEN_W] = LEN_W'(len);
    step();
  endtask

  task automatic ack(input int c);
    idle_inputs();
    HandShake_En[c] = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    Burst_Len = '0;
    ARESET = 1'b1;
    step(); step();
    check("rst_done", 32'(HandShake_Done), 32'd0);

    // Reset in the middle of a burst.
    start(0, 7);
    beat(0, 0); beat(0, 0); beat(0, 0);
    check("mid_bcnt", 32'(Beat_Count[7:0]), 32'd3);
    idle_inputs(); ARESET = 1'b1; step(); step();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_bc",   32'(Beat_Count), 32'd0);
    beat(0, 1);
    check("rst_nostart", 32'(HandShake_Done), 32'd0);

    // Nominal burst of four beats.
    start(0, 3);
    beat(0, 0); beat(0, 0); beat(0, 0); beat(0, 1);
    check("nom_done", 32'(HandShake_Done[0]), 32'd1);
    check("nom_bc",   32'(Beat_Count[7:0]), 32'd3);
    idle_inputs(); step();
    check("nom_hold", 32'(HandShake_Done[0]), 32'd1);
    ack(0);
    check("nom_ack",  32'(HandShake_Done[0]), 32'd0);

    // Early WLAST; the subsequent beats must be ignored.
    start(1, 5);
    beat(1, 0); beat(1, 0); beat(1, 1);
    beat(1, 0); beat(1, 0); beat(1, 1);
    check("early_err", 32'(Len_Err[1]), 32'd1);
    check("early_bc",  32'(Beat_Count[15:8]), 32'd2);
    ack(1);

    // Missing WLAST on the final beat.
    start(0, 1);
    beat(0, 0); beat(0, 0);
    check("late_err", 32'(Len_Err[0]), 32'd1);

    // Acknowledge and start in the same cycle.
    idle_inputs();
    HandShake_En[0] = 1'b1; Burst_Start[0] = 1'b1; Burst_Len[7:0] = 8'd0;
    step();
    check("b2b_busy", 32'(Busy[0]), 32'd1);
    check("b2b_err",  32'(Len_Err[0]), 32'd0);
    beat(0, 1);
    check("b2b_done", 32'(HandShake_Done[0]), 32'd1);

    // Concurrent bursts on both channels with stalls, after a fresh reset.
    idle_inputs(); ARESET = 1'b1; step();
    idle_inputs();
    Burst_Start = 2'b11; Burst_Len = {8'd0, 8'd2};
    step();
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      Valid_Signal = 2'(k % 3 != 1 ? 2'b01 : 2'b10) | 2'(k == 5 ? 2'b10 : 2'b00);
      Ready_Signal = 2'(k % 2 == 0 ? 2'b11 : 2'b10);
      Last_Data    = 2'b11;
      Last_Data[0] = (m_beats[0] + 1 == m_total[0]);
      step();
    end
    check("ind_done", 32'(HandShake_Done), 32'd3);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      idle_inputs();
      ARESET = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        Burst_Start[c]  = ($urandom_range(0, 3) == 0);
        Burst_Len[c*LEN_W +: LEN_W] = ($urandom_range(0, 15) == 0) ?
                                      LEN_W'($urandom_range(0, 255)) :
                                      LEN_W'($urandom_range(0, 5));
        Valid_Signal[c] = ($urandom_range(0, 9) < 7);
        Ready_Signal[c] = ($urandom_range(0, 9) < 7);
        Last_Data[c]    = ($urandom_range(0, 9) < 8) ?
                          (m_beats[c] + 1 == m_total[c]) : 1'($urandom_range(0, 1));
        HandShake_En[c] = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
